// File: rtl/seg7_pkg.sv
// Shared digit patterns and encode function for the 7-segment decoder.
// Patterns are active-high, bit order {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;
  localparam seg_t SEG_ALL = 7'b1111111;

  localparam seg_t P0 = 7'b1111110;
  localparam seg_t P1 = 7'b0110000;
  localparam seg_t P2 = 7'b1101101;
  localparam seg_t P3 = 7'b1111001;
  localparam seg_t P4 = 7'b0110011;
  localparam seg_t P5 = 7'b1011011;
  localparam seg_t P6 = 7'b1011111;
  localparam seg_t P7 = 7'b1110000;
  localparam seg_t P8 = 7'b1111111;
  localparam seg_t P9 = 7'b1111011;
  localparam seg_t PA = 7'b1110111;
  localparam seg_t PB = 7'b0011111;
  localparam seg_t PC = 7'b1001110;
  localparam seg_t PD = 7'b0111101;
  localparam seg_t PE = 7'b1001111;
  localparam seg_t PF = 7'b1000111;

  function automatic seg_t seg7_encode(
    input logic [3:0] bcd,
    input logic       hex_en
  );
    seg_t p;
    p = SEG_OFF;
    case (bcd)
      4'd0:  p = P0;
      4'd1:  p = P1;
      4'd2:  p = P2;
      4'd3:  p = P3;
      4'd4:  p = P4;
      4'd5:  p = P5;
      4'd6:  p = P6;
      4'd7:  p = P7;
      4'd8:  p = P8;
      4'd9:  p = P9;
      4'd10: p = hex_en ? PA : SEG_OFF;
      4'd11: p = hex_en ? PB : SEG_OFF;
      4'd12: p = hex_en ? PC : SEG_OFF;
      4'd13: p = hex_en ? PD : SEG_OFF;
      4'd14: p = hex_en ? PE : SEG_OFF;
      default: p = hex_en ? PF : SEG_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/segment_7_if.sv
// Digit-value bundle from upstream logic and segment drive back out.
// master = digit source, slave = decoder.
interface segment_7_if;
  import seg7_pkg::*;

  logic [3:0] bcd;
  logic       lamp_test;
  logic       blank;
  logic       rbi;
  seg_t       seg;
  logic       rbo;

  modport master (
    output bcd, lamp_test, blank, rbi,
    input  seg, rbo
  );

  modport slave (
    input  bcd, lamp_test, blank, rbi,
    output seg, rbo
  );

endinterface

// File: rtl/seg7_lut.sv
// Combinational 4-bit code to active-high segment pattern lookup.
// HEX_EN selects A-F glyphs or blanking for codes 10-15.
module seg7_lut
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] bcd,
  output seg_t       pat
);

  assign pat = seg7_encode(bcd, HEX_EN);

endmodule

// File: rtl/segment_7.sv
// Registered 7-segment digit decoder with lamp test, blanking
// and 7447-style ripple blanking.
module segment_7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  segment_7_if.slave   bus
);

  localparam seg_t SEG_RST = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  seg_t pat;
  seg_t raw_next;
  seg_t seg_next;
  logic rbo_next;
  logic zero_sup;

  seg7_lut #(
    .HEX_EN (HEX_EN)
  ) u_lut (
    .bcd (bus.bcd),
    .pat (pat)
  );

  assign zero_sup = bus.rbi && (bus.bcd == 4'd0);

  // Overlapping controls resolve by priority, lamp test first.
  always_comb begin
    raw_next = pat;
    rbo_next = 1'b0;
    priority case (1'b1)
      bus.lamp_test: raw_next = SEG_ALL;
      bus.blank:     raw_next = SEG_OFF;
      zero_sup: begin
        raw_next = SEG_OFF;
        rbo_next = 1'b1;
      end
      default:       raw_next = pat;
    endcase
    seg_next = ACTIVE_LOW ? ~raw_next : raw_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg <= SEG_RST;
      bus.rbo <= 1'b0;
    end else begin
      bus.seg <= seg_next;
      bus.rbo <= rbo_next;
    end
  end

endmodule

// File: tb/tb_segment_7.sv
// Self-checking bench: four parameter builds driven in parallel,
// checked against a table-driven reference model.
module tb_segment_7;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  segment_7_if b0 ();
  segment_7_if b1 ();
  segment_7_if b2 ();
  segment_7_if b3 ();

  segment_7 #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  segment_7 #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  segment_7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  segment_7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16];
  logic [3:0] c_bcd;
  logic       c_lt, c_bl, c_rbi;

  initial begin
    glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000;
    glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
    glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
    glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
    glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011;
    glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
    glyph[12] = 7'b1001110; glyph[13] = 7'b0111101;
    glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
  end

  function automatic logic [6:0] ref_seg(
    input logic [3:0] v, input logic lt, input logic bl,
    input logic ri, input bit hex, input bit al
  );
    logic [6:0] p;
    if (lt)                   p = 7'h7f;
    else if (bl)              p = 7'h00;
    else if (ri && v == 0)    p = 7'h00;
    else if (v > 9 && !hex)   p = 7'h00;
    else                      p = glyph[v];
    return al ? ~p : p;
  endfunction

  function automatic logic ref_rbo(
    input logic [3:0] v, input logic lt, input logic bl,
    input logic ri
  );
    return !lt && !bl && ri && (v == 0);
  endfunction

  task automatic cmp(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic lt,
                       input logic bl, input logic ri);
    c_bcd = v; c_lt = lt; c_bl = bl; c_rbi = ri;
    b0.bcd = v; b0.lamp_test = lt; b0.blank = bl; b0.rbi = ri;
    b1.bcd = v; b1.lamp_test = lt; b1.blank = bl; b1.rbi = ri;
    b2.bcd = v; b2.lamp_test = lt; b2.blank = bl; b2.rbi = ri;
    b3.bcd = v; b3.lamp_test = lt; b3.blank = bl; b3.rbi = ri;
  endtask

  task automatic check_all(input string tag);
    logic r;
    r = ref_rbo(c_bcd, c_lt, c_bl, c_rbi);
    cmp({tag, "/u0.seg"}, b0.seg,
        ref_seg(c_bcd, c_lt, c_bl, c_rbi, 1'b0, 1'b0));
    cmp({tag, "/u1.seg"}, b1.seg,
        ref_seg(c_bcd, c_lt, c_bl, c_rbi, 1'b1, 1'b0));
    cmp({tag, "/u2.seg"}, b2.seg,
        ref_seg(c_bcd, c_lt, c_bl, c_rbi, 1'b0, 1'b1));
    cmp({tag, "/u3.seg"}, b3.seg,
        ref_seg(c_bcd, c_lt, c_bl, c_rbi, 1'b1, 1'b1));
    cmp({tag, "/u0.rbo"}, {6'd0, b0.rbo}, {6'd0, r});
    cmp({tag, "/u1.rbo"}, {6'd0, b1.rbo}, {6'd0, r});
    cmp({tag, "/u2.rbo"}, {6'd0, b2.rbo}, {6'd0, r});
    cmp({tag, "/u3.rbo"}, {6'd0, b3.rbo}, {6'd0, r});
  endtask

  task automatic step(input string tag, input logic [3:0] v,
                      input logic lt, input logic bl, input logic ri);
    drive(v, lt, bl, ri);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "/u0.seg"}, b0.seg, 7'b0000000);
    cmp({tag, "/u1.seg"}, b1.seg, 7'b0000000);
    cmp({tag, "/u2.seg"}, b2.seg, 7'b1111111);
    cmp({tag, "/u3.seg"}, b3.seg, 7'b1111111);
    cmp({tag, "/u0.rbo"}, {6'd0, b0.rbo}, 7'd0);
    cmp({tag, "/u3.rbo"}, {6'd0, b3.rbo}, 7'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(4'd8, 1'b0, 1'b0, 1'b0);
    #12;
    check_reset("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      step($sformatf("dec%0d", i), 4'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 10; i < 16; i++)
      step($sformatf("hex%0d", i), 4'(i), 1'b0, 1'b0, 1'b0);

    step("pri_lt_bl", 4'd3, 1'b1, 1'b1, 1'b0);
    step("pri_bl",    4'd3, 1'b0, 1'b1, 1'b0);
    step("pri_rel",   4'd3, 1'b0, 1'b0, 1'b0);
    step("pri_lt_rb", 4'd0, 1'b1, 1'b0, 1'b1);
    step("pri_bl_rb", 4'd0, 1'b0, 1'b1, 1'b1);

    step("rb_zero",   4'd0, 1'b0, 1'b0, 1'b1);
    step("rb_five",   4'd5, 1'b0, 1'b0, 1'b1);
    step("rb_off0",   4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation while showing 8.
    step("pre_rst8",  4'd8, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  4'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'd0;
      step("rand", v,
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
